// File: rtl/pwm_dac_pkg.sv
// Shared constants and threshold helper for the slow-DAC PWM generator.
// Optional phase-align input is enabled with `define PWM_DAC_SYNC_EN.
package pwm_dac_pkg;

    localparam int unsigned PWW        = 8;
    localparam int unsigned DW         = 4;
    localparam int unsigned DITH_W     = 1 << DW;
    localparam int unsigned CCW        = PWW + DITH_W;
    localparam int unsigned THR_W      = PWW + 1;

    localparam int unsigned DUTY_MSB   = 23;
    localparam int unsigned DUTY_LSB   = 16;
    localparam int unsigned DITH_MSB   = 15;

    localparam int unsigned FRAME_CLKS = (1 << PWW) * (1 << DW);

    // Base duty plus the dither bit selected by the current period index.
    function automatic logic [THR_W-1:0] calc_thr(input logic [CCW-1:0] cfg,
                                                  input logic [DW-1:0]  cyc);
        logic [DITH_MSB:0] dith;
        dith = cfg[DITH_MSB:0];
        return {1'b0, cfg[DUTY_MSB:DUTY_LSB]} + THR_W'(dith[cyc]);
    endfunction

endpackage

// File: rtl/pwm_dac_timebase.sv
// Period/frame counters and frame-boundary strobe for pwm_dac_gen.
// With PWM_DAC_SYNC_EN, sync_i restarts the frame and forces a config load.
module pwm_dac_timebase
    import pwm_dac_pkg::*;
(
    input  logic           clk_i,
    input  logic           rstn_i,
`ifdef PWM_DAC_SYNC_EN
    input  logic           sync_i,
`endif
    output logic [PWW-1:0] cnt_o,
    output logic [DW-1:0]  cyc_o,
    output logic           load_c_o,
    output logic           frame_o
);

    logic [PWW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]  cyc_q, cyc_d;
    logic           frame_q;
    logic           load_c;

    // Next-count and boundary detection; sync wins over free running.
    always_comb begin
        cnt_d  = cnt_q + PWW'(1);
        cyc_d  = cyc_q;
        load_c = 1'b0;
        if (&cnt_q) begin
            cyc_d = cyc_q + DW'(1);
            if (&cyc_q) begin
                load_c = 1'b1;
            end
        end
`ifdef PWM_DAC_SYNC_EN
        if (sync_i) begin
            cnt_d  = '0;
            cyc_d  = '0;
            load_c = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q   <= '0;
            cyc_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            frame_q <= load_c;
        end
    end

    assign cnt_o    = cnt_q;
    assign cyc_o    = cyc_q;
    assign load_c_o = load_c;
    assign frame_o  = frame_q;

endmodule

// File: rtl/pwm_dac_gen.sv
// Dithered PWM DAC: turns a {duty, dither} config word into a 1-bit stream.
// Define PWM_DAC_SYNC_EN to add the sync_i phase-align input.
module pwm_dac_gen
    import pwm_dac_pkg::*;
(
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic [CCW-1:0] cfg_i,
`ifdef PWM_DAC_SYNC_EN
    input  logic           sync_i,
`endif
    output logic           pwm_o,
    output logic           frame_o
);

    logic [PWW-1:0]   cnt;
    logic [DW-1:0]    cyc;
    logic             load_c;
    logic [CCW-1:0]   cfg_q, cfg_d;
    logic             pwm_q, pwm_d;
    logic [THR_W-1:0] thr_c;

    pwm_dac_timebase u_timebase (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
`ifdef PWM_DAC_SYNC_EN
        .sync_i   (sync_i),
`endif
        .cnt_o    (cnt),
        .cyc_o    (cyc),
        .load_c_o (load_c),
        .frame_o  (frame_o)
    );

    // Threshold reaches 2**PWW when duty is all-ones and the dither bit is set.
    always_comb begin
        cfg_d = cfg_q;
        if (load_c) begin
            cfg_d = cfg_i;
        end
        thr_c = calc_thr(cfg_q, cyc);
        pwm_d = ({1'b0, cnt} < thr_c);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cfg_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: tb/tb_pwm_dac_gen.sv
// Directed self-checking bench for pwm_dac_gen (sync test under PWM_DAC_SYNC_EN).
module tb_pwm_dac_gen;

    logic        clk_i  = 1'b0;
    logic        rstn_i = 1'b0;
    logic [23:0] cfg_i  = 24'h800000;
`ifdef PWM_DAC_SYNC_EN
    logic        sync_i = 1'b0;
`endif
    logic        pwm_o;
    logic        frame_o;

    int n_assert = 0;
    int n_fail   = 0;

    pwm_dac_gen dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .cfg_i   (cfg_i),
`ifdef PWM_DAC_SYNC_EN
        .sync_i  (sync_i),
`endif
        .pwm_o   (pwm_o),
        .frame_o (frame_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Step n edges; count high pwm samples, last high index, frame pulses, last pulse index.
    task automatic run(input int n, output int hi, output int last_hi,
                       output int fr, output int fr_idx);
        hi = 0; last_hi = -1; fr = 0; fr_idx = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (pwm_o === 1'b1) begin
                hi++;
                last_hi = i;
            end
            if (frame_o === 1'b1) begin
                fr++;
                fr_idx = i;
            end
        end
    endtask

    // One 256-clock period: high for exactly thr leading clocks.
    task automatic period(input string tag, input int thr, input int exp_fr, output int hi);
        int last_hi, fr, fr_idx;
        run(256, hi, last_hi, fr, fr_idx);
        check({tag, "_hi"}, hi, thr);
        check({tag, "_last"}, last_hi, thr - 1);
        check({tag, "_frame"}, fr, exp_fr);
    endtask

    initial begin
        int hi, last_hi, fr, fr_idx, sum;

        // Reset with 50% word applied.
        #23;
        check("rst_pwm", int'(pwm_o), 0);
        check("rst_frame", int'(frame_o), 0);
        tick();
        rstn_i = 1'b1;

        // Frame 0 runs on cleared config: all low, boundary pulse on last edge.
        run(4095, hi, last_hi, fr, fr_idx);
        check("f0_hi", hi, 0);
        check("f0_frame", fr, 0);
        run(1, hi, last_hi, fr, fr_idx);
        check("f0_end_frame", fr, 1);
        check("f0_end_hi", hi, 0);
        for (int p = 0; p < 2; p++) period("half", 128, 0, hi);

        // Mid-frame change to zero waits for the boundary.
        cfg_i = 24'h000000;
        run(3584, hi, last_hi, fr, fr_idx);
        check("half_rest_hi", hi, 1792);
        check("half_rest_frame", fr, 1);
        run(12288, hi, last_hi, fr, fr_idx);
        check("zero_hi", hi, 0);
        check("zero_frame", fr, 3);

        // Full scale: one more zero frame, then constant high.
        cfg_i = 24'hFFFFFF;
        run(4096, hi, last_hi, fr, fr_idx);
        check("pre_full_hi", hi, 0);
        run(4096, hi, last_hi, fr, fr_idx);
        check("full_hi", hi, 4096);
        check("full_frame", fr, 1);
        cfg_i = 24'h105555;
        run(4096, hi, last_hi, fr, fr_idx);
        check("full2_hi", hi, 4096);

        // Alternating dither: 17/16 starting with 17.
        sum = 0;
        for (int p = 0; p < 15; p++) begin
            period("alt", (p % 2 == 0) ? 17 : 16, 0, hi);
            sum += hi;
        end
        cfg_i = 24'h100080;
        period("alt15", 16, 1, hi);
        sum += hi;
        check("alt_total", sum, 264);

        // Single dither bit in period 7.
        for (int p = 0; p < 15; p++) period("bit7", (p == 7) ? 17 : 16, 0, hi);
        cfg_i = 24'h400000;
        run(256, hi, last_hi, fr, fr_idx);
        check("bit7_p15_hi", hi, 16);
        check("bit7_frame_idx", fr_idx, 255);

        // Change at cyc 5 only takes effect after the boundary.
        for (int p = 0; p < 5; p++) period("q1", 64, 0, hi);
        cfg_i = 24'hC00000;
        for (int p = 5; p < 15; p++) period("q1_late", 64, 0, hi);
        period("q1_p15", 64, 1, hi);
        period("q3", 192, 0, hi);

        // Asynchronous reset while pwm is high.
        run(10, hi, last_hi, fr, fr_idx);
        check("pre_rst_pwm", int'(pwm_o), 1);
        #1;
        rstn_i = 1'b0;
        #1;
        check("async_rst_pwm", int'(pwm_o), 0);
        check("async_rst_frame", int'(frame_o), 0);
        tick(); tick();
        rstn_i = 1'b1;
        run(4095, hi, last_hi, fr, fr_idx);
        check("rr_f0_hi", hi, 0);
        check("rr_f0_frame", fr, 0);
        run(1, hi, last_hi, fr, fr_idx);
        check("rr_f0_end_frame", fr, 1);
        period("rr_q3", 192, 0, hi);

`ifdef PWM_DAC_SYNC_EN
        // Sync at cnt 100 restarts period 0 and loads the new word.
        run(100, hi, last_hi, fr, fr_idx);
        check("sync_pre_hi", hi, 100);
        cfg_i  = 24'h800000;
        sync_i = 1'b1;
        tick();
        sync_i = 1'b0;
        check("sync_frame", int'(frame_o), 1);
        check("sync_pwm", int'(pwm_o), 1);
        period("sync_half", 128, 0, hi);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_dac_gen.md
Name: pwm_dac_gen

Overview:
- Consumer end of the 24-bit PWM DAC configuration words produced by the analog mixed-signal block (dac_a_o..dac_d_o).
- Turns one config word into a single-bit PWM stream for the RC-filtered slow analog outputs.
- Word layout: cfg[23:16] is the 8-bit base duty; cfg[15:0] is a 16-entry dither sequence. Dither bit k lengthens the high time of PWM period k (k = 0..15) by one clock.
- One instance per slow DAC channel. Runs in the 250 MHz PWM clock domain.

Parameters:
- CCW, 24, config word width; must equal PWW + 2**DW.
- PWW, 8, base period counter width; period = 2**PWW clocks.
- DW, 4, dither index width; frame = 2**DW periods.

Ports:
- clk_i  in  1  PWM clock.
- rstn_i  in  1  reset: asynchronous assert, active-low.
- cfg_i  in  CCW  config word {duty[7:0], dither[15:0]}; may change on any clock.
- pwm_o  out  1  registered PWM output.
- frame_o  out  1  one-clock pulse marking the first clock of each frame.

Behaviour:
- Reset: rstn_i low clears the following immediately, without waiting for a clock edge:
  - cnt (PWW bits) = 0, cyc (DW bits) = 0, cfg_r = 0.
  - pwm_o = 0, frame_o = 0.
- Reset release: the first rising edge with rstn_i high is period 0 of frame 0, running on cfg_r = 0, so the output is low for that whole first frame.
- Counters:
  - cnt increments every clock and wraps 255 -> 0.
  - When cnt == 255, cyc increments and wraps 15 -> 0.
- Config latch: on the edge where cnt == 255 and cyc == 15:
  - cfg_r <= cfg_i.
  - frame_o <= 1 for exactly one clock; frame_o = 0 on all other clocks.
  - cfg_i is sampled only at this edge. Changes at any other time have no effect until the next frame boundary.
  - Worst-case latency from a cfg_i change to its effect: 4096 + 1 clocks.
- Threshold (combinational, 9-bit unsigned): thr = {1'b0, cfg_r[23:16]} + cfg_r[cyc].
  - Bit 15 of the dither field is honoured if set, even though the producer always drives 0.
- Output: pwm_o <= ({1'b0, cnt} < thr), registered, lagging cnt by 1 clock.
  - Each period of pwm_o is high for exactly thr consecutive clocks, then low for 256 - thr clocks.
  - thr = 0 gives constant low.
  - thr = 256 (duty 0xFF with the dither bit set) gives constant high for that period, with no glitch.
- Averaging:
  - Mean over one frame = (16*duty + popcount(dither)) / 4096.
  - The output is monotonic in the 12-bit code formed by duty and the dither weights.
- Frame alignment: frame_o asserts on the same clock that pwm_o shows period 0 of the newly latched word (both are registered from the same edge).
- No handshake: cfg_i is a static level. The producer guarantees it is stable for at least 1 clock around the frame boundary. Metastability is not handled; the producer must share clk_i.

Optional Feature:
- Macro PWM_DAC_SYNC_EN.
- Defined:
  - Adds input port sync_i (1 bit).
  - sync_i high at a clock edge forces cnt = 0, cyc = 0 and cfg_r <= cfg_i on that edge, and pulses frame_o the following clock.
  - sync_i overrides normal counting when both occur on the same edge.
  - Purpose: phase-align the four channel instances.
- Not defined: no sync_i port; counters free-run from reset.

Decomposition:
- Shared package pwm_dac_pkg holds:
  - PWW, DW and CCW constants.
  - Field positions DUTY_MSB = 23, DUTY_LSB = 16, DITH_MSB = 15.
  - Frame length FRAME_CLKS = 4096.
- One sub-module, pwm_dac_timebase: the cnt/cyc counters plus frame-boundary and sync logic. It outputs cnt, cyc and the frame strobe.
- The top level holds cfg_r, the threshold computation and the comparator.

Test Plan:
- cfg_i = 24'h800000 held across reset release. Frame 0 is all low. From frame 1 on, every 256-clock period shows pwm_o high 128 clocks, then low 128.
- cfg_i = 24'h000000: pwm_o stays 0 for 3 frames. cfg_i = 24'hFFFFFF: after the next frame boundary, pwm_o is constantly 1 with no low clock.
- cfg_i = 24'h105555: periods alternate 17/16 high clocks, starting with 17 in period 0. Total high over one frame = 264.
- cfg_i = 24'h100080: only period 7 of each frame is high 17 clocks; all others are 16. frame_o pulses every 4096 clocks, coinciding with the period-0 rise.
- Change cfg_i 24'h400000 -> 24'hC00000 at cyc = 5: remaining periods of the frame stay at 64 high. The first 192-high period starts 1 clock after the boundary latch.
- Assert rstn_i low mid-period while pwm_o = 1: pwm_o drops to 0 with no clock edge. After release the counters restart at 0. With PWM_DAC_SYNC_EN, a sync_i pulse at cnt = 100 restarts period 0 on the next edge and frame_o pulses.
